board_indexer: RTL and testbench
================================

Name: board_indexer

Overview:
- Wishbone master that sits directly upstream of the board memory slave and fills in each cell's mine-neighbour count after mines are placed.
- On a start pulse it sweeps an N×N board in raster order. For each cell it reads the cell and its in-bounds neighbours, then writes the cell back with the mine_ind field set to the number of neighbouring mines.
- Reports completion, the total mine count and a bus error flag to the game controller.

Parameters:
- ACK_TIMEOUT, 16: maximum cycles to wait for ACK_I after a strobe before aborting.
- MAX_SIZE, 16: largest board edge; fixed by the 4-bit row/column address split.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- board_size  in  5  board edge N, latched on start
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end (normal or aborted)
- error  out  1  set with done on ACK timeout; held until next start
- mine_total  out  9  number of cells with mine bit set; valid from the done pulse until the next start
- CYC_O  out  1  bus cycle active
- STB_O  out  1  strobe
- WE_O  out  1  1 = write
- ADR_O  out  8  {row[3:0], col[3:0]}
- DAT_O  out  8  write data
- DAT_I  in  8  read data, valid in the ACK_I cycle
- ACK_I  in  1  slave acknowledge, registered by the slave

Behaviour:
- Clock and reset: single clock CLK_I. RST_I is asynchronous and active-high.
- Reset values: all outputs 0. The FSM goes to IDLE. A reset mid-sweep drops CYC_O/STB_O immediately, with no done pulse.
- Field layout: bit7 mine, bit6 flag, bit5 defused, bits4:1 mine_ind, bit0 reserved.
- board_size latching: latched on start. Values greater than 16 clamp to 16. A value of 0 gives a done pulse on the next cycle with no bus activity and mine_total = 0. A value of 1 processes the single cell with count 0.
- Bus rule, per transaction:
  - Assert CYC_O and STB_O for exactly one cycle with ADR_O/WE_O/DAT_O valid.
  - Then hold CYC_O = 1, STB_O = 0 and the address/data stable until ACK_I.
  - Capture DAT_I in the ACK cycle, then drop CYC_O the next cycle.
  - With the standard slave, each transaction takes 3 cycles (strobe, ACK, release).
  - ACK_I outside a wait phase is ignored. Only one transaction is outstanding at a time.
- FSM states:
  - IDLE: on start go to RD_CENTER with row = col = 0. Clear error and mine_total.
  - RD_CENTER: read (row,col) and store it as the center byte. If the mine bit is set, increment mine_total. Clear the neighbour counter nb and the mine count cnt.
  - RD_NEIGH: nb runs 0..7 with offsets (-1,-1), (-1,0), (-1,+1), (0,-1), (0,+1), (+1,-1), (+1,0), (+1,+1).
    - An out-of-bounds neighbour (row/col < 0 or ≥ N) consumes one cycle with no bus activity.
    - An in-bounds neighbour is read; cnt increments if DAT_I[7] is set.
    - After nb = 7, go to WR_CENTER.
  - WR_CENTER: write DAT_O = {center[7:5], cnt[3:0], center[0]}. Mine cells are also written with their count.
  - NEXT: increment col; on col = N-1, wrap to 0 and increment row. After (N-1, N-1), go to DONE; otherwise go to RD_CENTER. Takes one cycle.
  - DONE: pulse done for 1 cycle, deassert busy, return to IDLE.
- Timeout: a wait-cycle counter restarts at each strobe. If ACK_TIMEOUT cycles pass without ACK_I, drop CYC_O, set error, and go to DONE. No further writes occur.
- Width rules: cnt is at most 8 and fits in 4 bits. mine_total is at most 256 and fits in 9 bits. No wrap is possible.
- busy: 1 from the cycle after start through the done cycle inclusive. start while busy has no effect.

Test Plan:
- N = 2, memory cleared except (0,0) = 0x80, start → four writes:
  - ADR 0x00 DAT 0x80
  - ADR 0x01 DAT 0x02
  - ADR 0x10 DAT 0x02
  - ADR 0x11 DAT 0x02
  - then done = 1, mine_total = 1, error = 0.
- N = 16, all cells 0x80 → corner cells written 0x86, edge cells 0x8A, interior cells 0x90. mine_total = 256. Bus model checks STB_O is high for exactly one cycle per transaction.
- N = 3, cell (1,1) = 0x60 (flag + defused), mines at (0,0) and (2,2) → (1,1) written 0x64, so flag/defused/reserved bits are preserved. (0,1) written 0x02.
- Slave never asserts ACK_I → CYC_O drops ACK_TIMEOUT cycles after the first strobe. done and error are both 1 in the same cycle, and no write is issued.
- RST_I asserted mid-sweep → CYC_O, STB_O, busy and done are all 0 in the same cycle. A new start with N = 0 → done the next cycle, no CYC_O, mine_total = 0.
- start pulsed again while busy during an N = 2 sweep → the sweep completes unchanged with exactly 4 writes and 1 done pulse.

Source files
------------

// File: rtl/board_indexer.sv
// board_indexer: Wishbone master that sweeps an N x N board in raster order and writes
// each cell back with its neighbouring-mine count in bits 4:1.
module board_indexer #(
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_SIZE    = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       start,
    input  logic [4:0] board_size,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [8:0] mine_total,
    output logic       CYC_O,
    output logic       STB_O,
    output logic       WE_O,
    output logic [7:0] ADR_O,
    output logic [7:0] DAT_O,
    input  logic [7:0] DAT_I,
    input  logic       ACK_I,
    output logic [2:0] dbg_state
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_CENTER, S_RD_NEIGH, S_WR_CENTER, S_NEXT, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_STB, PH_WAIT, PH_REL} phase_t;

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [4:0]     n_q, n_d;
    logic [3:0]     row_q, row_d, col_q, col_d;
    logic [2:0]     nb_q, nb_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     center_q, center_d;
    logic [8:0]     total_q, total_d;
    logic           err_q, err_d;
    logic [TW-1:0]  wait_q, wait_d;

    logic signed [5:0] dr, dc, nr, nc;
    logic              nb_in;
    logic              bus_req, bus_we;
    logic [7:0]        bus_adr, bus_dat;
    logic              ack_hit, rel_hit;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_STB;
            n_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            nb_q     <= '0;
            cnt_q    <= '0;
            center_q <= '0;
            total_q  <= '0;
            err_q    <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            n_q      <= n_d;
            row_q    <= row_d;
            col_q    <= col_d;
            nb_q     <= nb_d;
            cnt_q    <= cnt_d;
            center_q <= center_d;
            total_q  <= total_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
        end
    end

    // Neighbour offset table and the bus request each state wants to make.
    always_comb begin
        dr = '0;
        dc = '0;
        case (nb_q)
            3'd0:    begin dr = -6'sd1; dc = -6'sd1; end
            3'd1:    begin dr = -6'sd1; dc =  6'sd0; end
            3'd2:    begin dr = -6'sd1; dc =  6'sd1; end
            3'd3:    begin dr =  6'sd0; dc = -6'sd1; end
            3'd4:    begin dr =  6'sd0; dc =  6'sd1; end
            3'd5:    begin dr =  6'sd1; dc = -6'sd1; end
            3'd6:    begin dr =  6'sd1; dc =  6'sd0; end
            default: begin dr =  6'sd1; dc =  6'sd1; end
        endcase
        nr    = $signed({2'b00, row_q}) + dr;
        nc    = $signed({2'b00, col_q}) + dc;
        nb_in = !nr[5] && (nr[4:0] < n_q) && !nc[5] && (nc[4:0] < n_q);

        bus_req = 1'b0;
        bus_we  = 1'b0;
        bus_adr = {row_q, col_q};
        bus_dat = {center_q[7:5], cnt_q, center_q[0]};
        case (state_q)
            S_RD_CENTER: bus_req = 1'b1;
            S_RD_NEIGH: begin
                bus_req = nb_in;
                bus_adr = {nr[3:0], nc[3:0]};
            end
            S_WR_CENTER: begin
                bus_req = 1'b1;
                bus_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        n_d      = n_q;
        row_d    = row_q;
        col_d    = col_q;
        nb_d     = nb_q;
        cnt_d    = cnt_q;
        center_d = center_q;
        total_d  = total_q;
        err_d    = err_q;
        wait_d   = wait_q;
        ack_hit  = 1'b0;
        rel_hit  = 1'b0;
        CYC_O    = 1'b0;
        STB_O    = 1'b0;
        WE_O     = 1'b0;
        ADR_O    = '0;
        DAT_O    = '0;

        // Transaction phases: one strobe cycle, wait for ACK, one release cycle with CYC low.
        if (bus_req) begin
            case (phase_q)
                PH_STB: begin
                    CYC_O   = 1'b1;
                    STB_O   = 1'b1;
                    wait_d  = TW'(1);
                    phase_d = PH_WAIT;
                end
                PH_WAIT: begin
                    CYC_O = 1'b1;
                    if (ACK_I) begin
                        ack_hit = 1'b1;
                        phase_d = PH_REL;
                    end else if (wait_q >= TW'(ACK_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        phase_d = PH_STB;
                        state_d = S_DONE;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
                default: begin
                    rel_hit = 1'b1;
                    phase_d = PH_STB;
                end
            endcase
            if (CYC_O) begin
                WE_O  = bus_we;
                ADR_O = bus_adr;
                DAT_O = bus_we ? bus_dat : 8'h00;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = (board_size > 5'(MAX_SIZE)) ? 5'(MAX_SIZE) : board_size;
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                    total_d = '0;
                    phase_d = PH_STB;
                    state_d = (board_size == 5'd0) ? S_DONE : S_RD_CENTER;
                end
            end
            S_RD_CENTER: begin
                if (ack_hit) begin
                    center_d = DAT_I;
                    if (DAT_I[7]) total_d = total_q + 9'd1;
                end
                if (rel_hit) begin
                    nb_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RD_NEIGH;
                end
            end
            S_RD_NEIGH: begin
                if (ack_hit && DAT_I[7]) cnt_d = cnt_q + 4'd1;
                // Off-board neighbours cost one idle cycle instead of a transaction.
                if (rel_hit || !nb_in) begin
                    if (nb_q == 3'd7) state_d = S_WR_CENTER;
                    else              nb_d    = nb_q + 3'd1;
                end
            end
            S_WR_CENTER: begin
                if (rel_hit) state_d = S_NEXT;
            end
            S_NEXT: begin
                if ({1'b0, col_q} == n_q - 5'd1) begin
                    col_d = '0;
                    if ({1'b0, row_q} == n_q - 5'd1) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = S_RD_CENTER;
                    end
                end else begin
                    col_d   = col_q + 4'd1;
                    state_d = S_RD_CENTER;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = err_q;
    assign mine_total = total_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_board_indexer.sv
// Bench for board_indexer: memory slave model, write scoreboard fed by a board-level
// neighbour-count model, and directed bus-timing / reset / timeout scenarios.
module tb_board_indexer;
    logic       CLK_I = 1'b0;
    logic       RST_I;
    logic       start;
    logic [4:0] board_size;
    logic       busy, done, error;
    logic [8:0] mine_total;
    logic       CYC_O, STB_O, WE_O;
    logic [7:0] ADR_O, DAT_O, DAT_I;
    logic       ACK_I;
    logic [2:0] dbg_state;

    logic [7:0]  mem [0:255];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          exp_total = 0;
    bit          ack_en = 1'b1;
    bit          stb_prev = 1'b0;

    board_indexer #(.ACK_TIMEOUT(16), .MAX_SIZE(16)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .board_size(board_size),
        .busy(busy), .done(done), .error(error), .mine_total(mine_total),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I), .dbg_state(dbg_state)
    );

    always #5 CLK_I = ~CLK_I;

    // Board memory slave: registered ACK one cycle after the strobe.
    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ACK_I <= 1'b0;
            DAT_I <= 8'h00;
        end else begin
            ACK_I <= CYC_O && STB_O && ack_en;
            if (CYC_O && STB_O) begin
                DAT_I <= mem[ADR_O];
                if (WE_O) mem[ADR_O] <= DAT_O;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK_I) begin
        if (RST_I) begin
            stb_prev = 1'b0;
        end else begin
            if (STB_O) chk("stb_single_cycle", {31'd0, stb_prev}, 32'd0);
            stb_prev = STB_O;
            if (CYC_O && STB_O && WE_O) begin
                wr_cnt++;
                if (exp_q.size() == 0) chk("unexpected_write", {16'd0, ADR_O, DAT_O}, 32'hFFFF_FFFF);
                else                   chk("write", {16'd0, ADR_O, DAT_O}, {16'd0, exp_q.pop_front()});
            end
            if (done) done_cnt++;
        end
    end

    task automatic mem_clear();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Reference: every cell written once, in raster order, with its mine-neighbour count.
    task automatic model_push(input logic [4:0] bs);
        int n;
        int cnt;
        int rr, cc;
        logic [7:0] v;
        logic [7:0] nv;
        n = (bs > 16) ? 16 : int'(bs);
        exp_total = 0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                v = mem[r * 16 + c];
                if (v[7]) exp_total++;
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        rr = r + dy;
                        cc = c + dx;
                        if (!(dy == 0 && dx == 0) && rr >= 0 && rr < n && cc >= 0 && cc < n) begin
                            nv = mem[rr * 16 + cc];
                            if (nv[7]) cnt++;
                        end
                    end
                end
                exp_q.push_back({8'(r * 16 + c), v[7:5], 4'(cnt), v[0]});
            end
        end
    endtask

    task automatic start_pulse(input logic [4:0] bs);
        @(negedge CLK_I);
        start = 1'b1;
        board_size = bs;
        @(negedge CLK_I);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK_I);
        end
    endtask

    task automatic run_sweep(input logic [4:0] bs, input string nm);
        int n;
        bit got;
        n = (bs > 16) ? 16 : int'(bs);
        start_pulse(bs);
        wait_done(40 * n * n + 20, got);
        chk({nm, "_done"}, {31'd0, got}, 32'd1);
        chk({nm, "_mine_total"}, {23'd0, mine_total}, exp_total);
        chk({nm, "_error"}, {31'd0, error}, 32'd0);
        chk({nm, "_writes_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit got;
        bit hi;
        int wc0, dc0;
        RST_I = 1'b1;
        start = 1'b0;
        board_size = 5'd0;
        mem_clear();
        repeat (3) @(negedge CLK_I);
        chk("rst_cyc", {31'd0, CYC_O}, 32'd0);
        chk("rst_stb", {31'd0, STB_O}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_total", {23'd0, mine_total}, 32'd0);
        chk("rst_adr_we", {23'd0, WE_O, ADR_O}, 32'd0);
        RST_I = 1'b0;
        @(negedge CLK_I);

        // N=2, single mine in the corner: fixed expected writes
        mem_clear();
        mem[8'h00] = 8'h80;
        exp_q.push_back(16'h0080);
        exp_q.push_back(16'h0102);
        exp_q.push_back(16'h1002);
        exp_q.push_back(16'h1102);
        exp_total = 1;
        run_sweep(5'd2, "n2");

        // N=3, flagged+defused centre keeps its upper and reserved bits
        mem_clear();
        mem[8'h00] = 8'h80;
        mem[8'h11] = 8'h60;
        mem[8'h22] = 8'h80;
        model_push(5'd3);
        run_sweep(5'd3, "n3");
        chk("n3_mem_11", {24'd0, mem[8'h11]}, 32'h64);
        chk("n3_mem_01", {24'd0, mem[8'h01]}, 32'h02);

        // N=16 all mines
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        model_push(5'd16);
        run_sweep(5'd16, "n16");
        chk("n16_corner", {24'd0, mem[8'hFF]}, 32'h86);
        chk("n16_edge", {24'd0, mem[8'h05]}, 32'h8A);
        chk("n16_interior", {24'd0, mem[8'h55]}, 32'h90);

        // Slave never acknowledges
        mem_clear();
        ack_en = 1'b0;
        wc0 = wr_cnt;
        start_pulse(5'd2);
        for (int i = 0; i < 5 && !STB_O; i++) @(negedge CLK_I);
        chk("to_strobe_seen", {31'd0, STB_O}, 32'd1);
        hi = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK_I);
            if (k < 16 && !CYC_O) hi = 1'b0;
        end
        chk("to_cyc_held", {31'd0, hi}, 32'd1);
        chk("to_cyc_dropped", {31'd0, CYC_O}, 32'd0);
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_error", {31'd0, error}, 32'd1);
        repeat (3) @(negedge CLK_I);
        chk("to_error_held", {31'd0, error}, 32'd1);
        chk("to_no_write", wr_cnt - wc0, 32'd0);
        ack_en = 1'b1;

        // start pulses while busy are ignored
        mem_clear();
        mem[8'h00] = 8'h80;
        model_push(5'd2);
        wc0 = wr_cnt;
        dc0 = done_cnt;
        start_pulse(5'd2);
        for (int p = 0; p < 3; p++) begin
            repeat (12) @(negedge CLK_I);
            start = 1'b1;
            board_size = 5'd5;
            @(negedge CLK_I);
            start = 1'b0;
        end
        wait_done(400, got);
        chk("busy_start_done", {31'd0, got}, 32'd1);
        chk("busy_start_error_cleared", {31'd0, error}, 32'd0);
        repeat (4) @(negedge CLK_I);
        chk("busy_start_writes", wr_cnt - wc0, 32'd4);
        chk("busy_start_dones", done_cnt - dc0, 32'd1);
        chk("busy_start_left", exp_q.size(), 32'd0);
        exp_q.delete();

        // Reset mid-sweep, then an empty board
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        start_pulse(5'd4);
        for (int i = 0; i < 20 && !CYC_O; i++) @(negedge CLK_I);
        repeat (4) @(negedge CLK_I);
        #2 RST_I = 1'b1;
        #1;
        chk("midrst_cyc", {31'd0, CYC_O}, 32'd0);
        chk("midrst_stb", {31'd0, STB_O}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        @(negedge CLK_I);
        RST_I = 1'b0;
        start_pulse(5'd0);
        chk("n0_done", {31'd0, done}, 32'd1);
        chk("n0_cyc", {31'd0, CYC_O}, 32'd0);
        chk("n0_total", {23'd0, mine_total}, 32'd0);
        @(negedge CLK_I);
        chk("n0_done_pulse", {31'd0, done}, 32'd0);

        // Random boards and sizes
        for (int t = 0; t < 5; t++) begin
            logic [4:0] bs;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
            bs = 5'($urandom_range(0, 9));
            model_push(bs);
            run_sweep(bs, "rand");
        end

        // Oversize board clamps to 16
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        model_push(5'd20);
        run_sweep(5'd20, "clamp");

        repeat (3) @(negedge CLK_I);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
